xadc_drp_arbiter: RTL

XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

---
 rtl/xadc_drp_pkg.sv | 18 +
 rtl/drp_rr_pick.sv | 17 +
 rtl/xadc_drp_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_pkg.sv
// Shared types and constants for the XADC DRP arbiter.
// FSM state encoding, default widths, requester indices.
package xadc_drp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } drp_state_e;

  localparam int ADDR_W_DFLT = 7;
  localparam int DATA_W_DFLT = 16;

  localparam logic REQ_POLL = 1'b0;
  localparam logic REQ_AXI  = 1'b1;

endpackage

// File: rtl/drp_rr_pick.sv
// Two-way round-robin pick for the DRP arbiter.
// valid[1:0] requests, last_grant index; grant is one-hot or zero.
module drp_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie, favour whoever did not win last time.
  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP port between two requesters, one op at a time.
// Ports: req0/req1 valid-ready-done channels, DRP port, arb_busy, timeout_cnt.
module xadc_drp_arbiter
  import xadc_drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = ADDR_W_DFLT,
  parameter int DATA_W         = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] DADDR,
  output logic              DEN,
  output logic [DATA_W-1:0] DI,
  output logic              DWE,
  input  logic [DATA_W-1:0] DO,
  input  logic              DRDY,
  output logic              arb_busy,
  output logic [7:0]        timeout_cnt
);

  drp_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [7:0]        tocnt_q, tocnt_d;
  logic [1:0]        grant;
  logic              rdy_ok;

  drp_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign rdy_ok     = (state_q == IDLE) && !rst;
  assign req0_ready = rdy_ok && grant[0];
  assign req1_ready = rdy_ok && grant[1];
  assign req0_done  = (state_q == DONE) && (owner_q == REQ_POLL);
  assign req1_done  = (state_q == DONE) && (owner_q == REQ_AXI);
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign DEN        = (state_q == ISSUE);
  assign DWE        = DEN && we_q;
  assign DADDR      = addr_q;
  assign DI         = wdata_q;
  assign arb_busy   = (state_q != IDLE);
  assign timeout_cnt = tocnt_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    tocnt_d      = tocnt_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d      = grant[1];
          last_grant_d = grant[1];
          addr_d       = grant[1] ? req1_addr : req0_addr;
          wdata_d      = grant[1] ? req1_wdata : req0_wdata;
          we_d         = grant[1] ? req1_we : req0_we;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // DRDY is checked first so a same-cycle timeout still succeeds.
        if (DRDY) begin
          if (owner_q == REQ_AXI) begin
            rdata1_d = DO;
            err1_d   = 1'b0;
          end else begin
            rdata0_d = DO;
            err0_d   = 1'b0;
          end
          state_d = DONE;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          if (owner_q == REQ_AXI) begin
            rdata1_d = '0;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = '0;
            err0_d   = 1'b1;
          end
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ_POLL;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      tocnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      tocnt_q      <= tocnt_d;
    end
  end

endmodule
